// File: rtl/operand_issue_pkg.sv
// Shared widths, opcodes, instruction field layout and decode helpers for operand_issue.
package operand_issue_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned REG_BITS   = 3;
    localparam int unsigned INSTR_BITS = 32;
    localparam int unsigned OP_BITS    = 4;
    localparam int unsigned IMM_BITS   = 16;

    // Field positions, bit 0 is the leftmost (most significant) bit of the word.
    localparam int unsigned OP_POS      = 0;
    localparam int unsigned USE_IMM_POS = 4;
    localparam int unsigned RD_POS      = 5;
    localparam int unsigned RS1_POS     = 8;
    localparam int unsigned RS2_POS     = 11;
    localparam int unsigned IMM_POS     = 16;

    typedef logic [0:OP_BITS-1]  opcode_t;
    typedef logic [0:REG_BITS-1] reg_idx_t;
    typedef logic [0:WORD_SIZE-1] word_t;

    localparam opcode_t ALU_ADD = 4'h0;
    localparam opcode_t ALU_SUB = 4'h1;
    localparam opcode_t ALU_MUL = 4'h2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    typedef struct packed {
        opcode_t               op;
        logic                  use_imm;
        reg_idx_t              rd;
        reg_idx_t              rs1;
        reg_idx_t              rs2;
        logic [0:IMM_BITS-1]   imm;
    } instr_t;

    function automatic instr_t decode(input logic [0:INSTR_BITS-1] w);
        instr_t d;
        d.op      = w[OP_POS +: OP_BITS];
        d.use_imm = w[USE_IMM_POS];
        d.rd      = w[RD_POS +: REG_BITS];
        d.rs1     = w[RS1_POS +: REG_BITS];
        d.rs2     = w[RS2_POS +: REG_BITS];
        d.imm     = w[IMM_POS +: IMM_BITS];
        return d;
    endfunction

    function automatic word_t sext_imm(input logic [0:IMM_BITS-1] imm);
        return {{(WORD_SIZE-IMM_BITS){imm[0]}}, imm};
    endfunction

    function automatic logic is_legal(input opcode_t op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_MUL);
    endfunction

endpackage

// File: rtl/operand_issue_if.sv
// Instruction, ALU-issue and writeback signals between operand_issue and its neighbours.
interface operand_issue_if;
    import operand_issue_pkg::*;

    logic [0:INSTR_BITS-1] instr;
    logic                  instr_valid;
    logic                  instr_ready;
    opcode_t               alu_op;
    word_t                 alu_in1;
    word_t                 alu_in2;
    logic                  alu_enable;
    reg_idx_t              alu_rd;
    logic                  wb_en;
    reg_idx_t              wb_addr;
    word_t                 wb_data;
    logic                  illegal;

    modport master (
        output instr, instr_valid, wb_en, wb_addr, wb_data,
        input  instr_ready, alu_op, alu_in1, alu_in2, alu_enable, alu_rd, illegal
    );

    modport slave (
        input  instr, instr_valid, wb_en, wb_addr, wb_data,
        output instr_ready, alu_op, alu_in1, alu_in2, alu_enable, alu_rd, illegal
    );
endinterface

// File: rtl/operand_issue_regfile_sb.sv
// Register file with busy scoreboard: two bypassed read ports, one writeback port, issue-time busy set.
module operand_issue_regfile_sb
    import operand_issue_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  reg_idx_t rd,
    input  logic     set_en,
    input  logic     wb_en,
    input  reg_idx_t wb_addr,
    input  word_t    wb_data,
    output word_t    rdata1_c,
    output word_t    rdata2_c,
    output logic     busy1_c,
    output logic     busy2_c,
    output logic     busy_rd_c
);

    word_t                regs [NUM_REGS];
    logic [NUM_REGS-1:0]  busy;
    logic                 wb_live;

    assign wb_live = wb_en && (wb_addr != '0);

    // Reads see a same-cycle writeback; a register being written back is no longer busy.
    always_comb begin
        rdata1_c  = (wb_live && (wb_addr == rs1)) ? wb_data : regs[rs1];
        rdata2_c  = (wb_live && (wb_addr == rs2)) ? wb_data : regs[rs2];
        busy1_c   = busy[rs1] && !(wb_live && (wb_addr == rs1));
        busy2_c   = busy[rs2] && !(wb_live && (wb_addr == rs2));
        busy_rd_c = busy[rd]  && !(wb_live && (wb_addr == rd));
    end

    // Register writes and scoreboard updates; the issue set is applied last so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_live) begin
                regs[wb_addr] <= wb_data;
                busy[wb_addr] <= 1'b0;
            end
            if (set_en && (rd != '0)) begin
                busy[rd] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_issue.sv
// Operand fetch and hazard-checked issue stage feeding the ALU.
module operand_issue
    import operand_issue_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    operand_issue_if.slave     bus
);

    state_t state, state_n;
    instr_t held;
    instr_t cur;
    logic   hazard;
    logic   issue;
    logic   drop;
    logic   capture;
    word_t  rdata1, rdata2;
    logic   busy1, busy2, busy_rd;

    assign cur = (state == S_STALL) ? held : decode(bus.instr);

    operand_issue_regfile_sb u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1       (cur.rs1),
        .rs2       (cur.rs2),
        .rd        (cur.rd),
        .set_en    (issue),
        .wb_en     (bus.wb_en),
        .wb_addr   (bus.wb_addr),
        .wb_data   (bus.wb_data),
        .rdata1_c  (rdata1),
        .rdata2_c  (rdata2),
        .busy1_c   (busy1),
        .busy2_c   (busy2),
        .busy_rd_c (busy_rd)
    );

    assign hazard = busy1 || (!cur.use_imm && busy2) || ((cur.rd != '0) && busy_rd);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and issue/drop/capture decisions.
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        drop    = 1'b0;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    if (!is_legal(cur.op)) begin
                        drop = 1'b1;
                    end else if (!hazard) begin
                        issue = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_n = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (!hazard) begin
                    issue   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered ALU drive, illegal pulse, ready flag and held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_op      <= '0;
            bus.alu_in1     <= '0;
            bus.alu_in2     <= '0;
            bus.alu_rd      <= '0;
            bus.alu_enable  <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.instr_ready <= 1'b1;
            held            <= '0;
        end else begin
            bus.alu_enable  <= issue;
            bus.illegal     <= drop;
            bus.instr_ready <= (state_n == S_IDLE);
            if (issue) begin
                bus.alu_op  <= cur.op;
                bus.alu_rd  <= cur.rd;
                bus.alu_in1 <= rdata1;
                bus.alu_in2 <= cur.use_imm ? sext_imm(cur.imm) : rdata2;
            end
            if (capture) begin
                held <= cur;
            end
        end
    end

endmodule

// File: tb/tb_operand_issue.sv
// Scoreboard bench for operand_issue: expected issues queued at drive time, checked when alu_enable fires.
module tb_operand_issue;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [2:0]  rd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   nchecks;
    int   nfail;
    exp_t sb [$];
    exp_t got;
    logic [31:0] mregs [8];

    operand_issue_if bus ();

    operand_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:31] mk(input logic [3:0] op, input logic ui, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm);
        return {op, ui, rd, rs1, rs2, 2'b00, imm};
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic exp_t ex(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rd);
        exp_t e;
        e.op = op; e.in1 = a; e.in2 = b; e.rd = rd;
        return e;
    endfunction

    // Compare every ALU issue against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.alu_enable === 1'b1) begin
            nchecks++;
            if (sb.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_issue: op=%h in1=%h in2=%h rd=%0d, required no issue",
                         bus.alu_op, bus.alu_in1, bus.alu_in2, bus.alu_rd);
            end else begin
                got = sb.pop_front();
                if (bus.alu_op !== got.op || bus.alu_in1 !== got.in1 ||
                    bus.alu_in2 !== got.in2 || bus.alu_rd !== got.rd) begin
                    nfail++;
                    $display("FAIL issue_payload: op=%h in1=%h in2=%h rd=%0d, required op=%h in1=%h in2=%h rd=%0d",
                             bus.alu_op, bus.alu_in1, bus.alu_in2, bus.alu_rd, got.op, got.in1, got.in2, got.rd);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] a, input logic [31:0] d);
        bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        tick();
        bus.wb_en = 1'b0;
        if (a != 3'd0) mregs[a] = d;
    endtask

    // Issue one hazard-free instruction and check the enable pulse appears on the next cycle.
    task automatic send(input string name, input logic [0:31] w, input exp_t e);
        sb.push_back(e);
        bus.instr = w; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        nchecks++;
        if (bus.alu_enable !== 1'b1) begin
            nfail++;
            $display("FAIL %s_enable: alu_enable=%b, required 1", name, bus.alu_enable);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(); tick();
        nchecks++;
        if (bus.alu_enable !== 1'b0 || bus.alu_op !== 4'h0 || bus.alu_in1 !== 32'h0 ||
            bus.alu_in2 !== 32'h0 || bus.alu_rd !== 3'd0 || bus.illegal !== 1'b0) begin
            nfail++;
            $display("FAIL reset_outputs: en=%b op=%h in1=%h in2=%h rd=%0d ill=%b, required all 0",
                     bus.alu_enable, bus.alu_op, bus.alu_in1, bus.alu_in2, bus.alu_rd, bus.illegal);
        end
        rst_n = 1'b1;
        tick();
        nchecks++;
        if (bus.instr_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_ready: instr_ready=%b, required 1", bus.instr_ready);
        end
    endtask

    task automatic test_add_imm;
        send("add_imm", mk(OP_ADD, 1'b1, 3'd1, 3'd0, 3'd0, 16'd5), ex(OP_ADD, 32'd0, 32'd5, 3'd1));
        wb(3'd1, 32'd7);
    endtask

    task automatic test_sext;
        send("sext", mk(OP_ADD, 1'b1, 3'd2, 3'd0, 3'd0, 16'hFFFF), ex(OP_ADD, 32'd0, sx(16'hFFFF), 3'd2));
        wb(3'd2, 32'h10);
    endtask

    task automatic test_raw_stall;
        send("raw_first", mk(OP_ADD, 1'b1, 3'd1, 3'd0, 3'd0, 16'd5), ex(OP_ADD, 32'd0, 32'd5, 3'd1));
        bus.instr = mk(OP_SUB, 1'b0, 3'd2, 3'd1, 3'd1, 16'd0); bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nchecks++;
            if (bus.instr_ready !== 1'b0 || bus.alu_enable !== 1'b0) begin
                nfail++;
                $display("FAIL raw_stall_%0d: ready=%b en=%b, required ready=0 en=0", i, bus.instr_ready, bus.alu_enable);
            end
            if (i < 2) tick();
        end
        sb.push_back(ex(OP_SUB, 32'd12, 32'd12, 3'd2));
        bus.wb_en = 1'b1; bus.wb_addr = 3'd1; bus.wb_data = 32'd12;
        tick();
        bus.wb_en = 1'b0; mregs[1] = 32'd12;
        nchecks++;
        if (bus.alu_enable !== 1'b1 || bus.instr_ready !== 1'b1) begin
            nfail++;
            $display("FAIL raw_release: en=%b ready=%b, required en=1 ready=1", bus.alu_enable, bus.instr_ready);
        end
        wb(3'd2, 32'd3);
    endtask

    task automatic test_waw_stall;
        send("waw_first", mk(OP_MUL, 1'b1, 3'd3, 3'd1, 3'd0, 16'd2), ex(OP_MUL, mregs[1], 32'd2, 3'd3));
        bus.instr = mk(OP_ADD, 1'b1, 3'd3, 3'd0, 3'd0, 16'd9); bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        nchecks++;
        if (bus.instr_ready !== 1'b0 || bus.alu_enable !== 1'b0) begin
            nfail++;
            $display("FAIL waw_stall: ready=%b en=%b, required ready=0 en=0", bus.instr_ready, bus.alu_enable);
        end
        sb.push_back(ex(OP_ADD, 32'd0, 32'd9, 3'd3));
        bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 32'd40;
        tick();
        bus.wb_en = 1'b0; mregs[3] = 32'd40;
        nchecks++;
        if (bus.alu_enable !== 1'b1) begin
            nfail++;
            $display("FAIL waw_release: alu_enable=%b, required 1", bus.alu_enable);
        end
        // r3 must still be busy from the second issue, so a reader of r3 stalls.
        bus.instr = mk(OP_ADD, 1'b1, 3'd4, 3'd3, 3'd0, 16'd0); bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        nchecks++;
        if (bus.instr_ready !== 1'b0 || bus.alu_enable !== 1'b0) begin
            nfail++;
            $display("FAIL waw_busy_kept: ready=%b en=%b, required ready=0 en=0", bus.instr_ready, bus.alu_enable);
        end
        sb.push_back(ex(OP_ADD, 32'd50, 32'd0, 3'd4));
        wb(3'd3, 32'd50);
        nchecks++;
        if (bus.alu_enable !== 1'b1) begin
            nfail++;
            $display("FAIL waw_reader_release: alu_enable=%b, required 1", bus.alu_enable);
        end
        wb(3'd4, 32'd8);
    endtask

    task automatic test_illegal;
        bus.instr = mk(4'hF, 1'b0, 3'd5, 3'd0, 3'd0, 16'd0); bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        nchecks++;
        if (bus.illegal !== 1'b1 || bus.alu_enable !== 1'b0 || bus.instr_ready !== 1'b1) begin
            nfail++;
            $display("FAIL illegal_pulse: ill=%b en=%b ready=%b, required ill=1 en=0 ready=1",
                     bus.illegal, bus.alu_enable, bus.instr_ready);
        end
        tick();
        nchecks++;
        if (bus.illegal !== 1'b0) begin
            nfail++;
            $display("FAIL illegal_width: illegal=%b, required 0", bus.illegal);
        end
        send("illegal_no_busy", mk(OP_ADD, 1'b1, 3'd6, 3'd5, 3'd0, 16'd1), ex(OP_ADD, mregs[5], 32'd1, 3'd6));
        wb(3'd6, 32'd21);
    endtask

    task automatic test_back_to_back;
        exp_t e [3];
        logic [0:31] w [3];
        w[0] = mk(OP_ADD, 1'b1, 3'd5, 3'd1, 3'd0, 16'd1);    e[0] = ex(OP_ADD, mregs[1], 32'd1, 3'd5);
        w[1] = mk(OP_SUB, 1'b0, 3'd6, 3'd2, 3'd3, 16'd0);    e[1] = ex(OP_SUB, mregs[2], mregs[3], 3'd6);
        w[2] = mk(OP_MUL, 1'b1, 3'd7, 3'd0, 3'd0, 16'hFFFE); e[2] = ex(OP_MUL, 32'd0, sx(16'hFFFE), 3'd7);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(e[i]);
            bus.instr = w[i];
            tick();
            nchecks++;
            if (bus.alu_enable !== 1'b1 || bus.instr_ready !== 1'b1) begin
                nfail++;
                $display("FAIL b2b_%0d: en=%b ready=%b, required en=1 ready=1", i, bus.alu_enable, bus.instr_ready);
            end
        end
        bus.instr_valid = 1'b0;
        tick();
        nchecks++;
        if (bus.alu_enable !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_end: alu_enable=%b, required 0", bus.alu_enable);
        end
        wb(3'd5, 32'd1); wb(3'd6, 32'd2); wb(3'd7, 32'd3);
    endtask

    task automatic test_reset_in_stall;
        send("rst_first", mk(OP_ADD, 1'b1, 3'd1, 3'd0, 3'd0, 16'd1), ex(OP_ADD, 32'd0, 32'd1, 3'd1));
        bus.instr = mk(OP_SUB, 1'b0, 3'd2, 3'd1, 3'd1, 16'd0); bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        nchecks++;
        if (bus.instr_ready !== 1'b0) begin
            nfail++;
            $display("FAIL rst_pre_stall: instr_ready=%b, required 0", bus.instr_ready);
        end
        rst_n = 1'b0;
        #1;
        nchecks++;
        if (bus.alu_enable !== 1'b0 || bus.alu_op !== 4'h0 || bus.alu_in1 !== 32'h0 ||
            bus.alu_in2 !== 32'h0 || bus.alu_rd !== 3'd0 || bus.illegal !== 1'b0) begin
            nfail++;
            $display("FAIL rst_stall_outputs: en=%b op=%h in1=%h in2=%h rd=%0d ill=%b, required all 0",
                     bus.alu_enable, bus.alu_op, bus.alu_in1, bus.alu_in2, bus.alu_rd, bus.illegal);
        end
        for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
        tick();
        rst_n = 1'b1;
        tick();
        nchecks++;
        if (bus.alu_enable !== 1'b0 || bus.instr_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rst_discard: en=%b ready=%b, required en=0 ready=1", bus.alu_enable, bus.instr_ready);
        end
        send("rst_after", mk(OP_ADD, 1'b1, 3'd1, 3'd1, 3'd0, 16'd3), ex(OP_ADD, 32'd0, 32'd3, 3'd1));
        wb(3'd1, 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nchecks = 0;
        nfail   = 0;
        for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
        bus.instr = '0; bus.instr_valid = 1'b0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        test_reset();
        test_add_imm();
        test_sext();
        test_raw_stall();
        test_waw_stall();
        test_illegal();
        test_back_to_back();
        test_reset_in_stall();
        @(negedge clk);
        #1;
        nchecks++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain: %0d issues outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Upstream neighbour of the ALU: accepts decoded instruction words, reads operands from an internal register file and drives the ALU's op, in1, in2 and enable inputs.
- Accepts ALU results on a writeback port.
- Keeps a per-register busy scoreboard and stalls on read-after-write or write-after-write hazards.
- One instruction in flight per destination register; the ALU is assumed to always accept a pulse on alu_enable.

Parameters:
- WORD_SIZE, 32, datapath width (from shared parameters.v).
- NUM_REGS, 8, register count; r0 reads as zero and is never marked busy.
- REG_BITS, 3, register index width (log2 NUM_REGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  [0:31]  instruction word: [0:3] opcode, [4] use_imm, [5:7] rd, [8:10] rs1, [11:13] rs2, [16:31] imm16 (sign-extended); bits [14:15] ignored.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  block can accept instr this cycle.
- alu_op  out  [0:3]  opcode to the ALU.
- alu_in1  out  [0:WORD_SIZE-1]  operand 1.
- alu_in2  out  [0:WORD_SIZE-1]  operand 2 (register or immediate).
- alu_enable  out  1  one-cycle issue pulse.
- alu_rd  out  [0:REG_BITS-1]  destination tag travelling with the issue.
- wb_en  in  1  writeback strobe.
- wb_addr  in  [0:REG_BITS-1]  writeback register.
- wb_data  in  [0:WORD_SIZE-1]  writeback value.
- illegal  out  1  one-cycle pulse when an unknown opcode is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=S_IDLE.
  - All registers and busy bits cleared.
  - alu_op, alu_in1, alu_in2, alu_rd = 0; alu_enable = 0; illegal = 0.
  - instr_ready = 1 once rst_n is released.
  - Reset mid-stall discards the held instruction.
- States:
  - S_IDLE: instr_ready=1. On instr_valid, capture instr.
    - If hazard-free: issue on the same edge, stay in S_IDLE.
    - Otherwise: go to S_STALL holding instr.
  - S_STALL: instr_ready=0. Re-evaluate the hazard each cycle on the held instr. When clear, issue and return to S_IDLE.
- Hazard rule:
  - Hazard exists if busy[rs1], busy[rs2] (only when use_imm=0), or busy[rd] (rd!=0) is set.
  - A register being written back this cycle (wb_en and wb_addr match) counts as not busy.
- Issue, on the edge of accept or stall exit:
  - alu_op <= opcode, alu_rd <= rd.
  - alu_in1 <= R[rs1]; alu_in2 <= use_imm ? sext(imm16) : R[rs2].
  - Same-cycle bypass: a matching wb_addr with wb_en supplies wb_data instead of the register file.
  - alu_enable is high for exactly the following cycle.
  - busy[rd] is set unless rd=0.
- Latency: accept at edge N with no hazard gives alu_enable=1 during cycle N+1. Back-to-back independent instructions issue every cycle.
- Writeback: R[wb_addr] <= wb_data and busy[wb_addr] cleared. Writes to r0 are ignored.
- Simultaneous writeback clear and issue set on the same rd: set wins.
- Illegal opcode (not ALU_ADD, ALU_SUB or ALU_MUL):
  - Accepted and dropped; no issue and no busy change.
  - illegal pulses for one cycle.
  - Never causes a stall.
- Width: imm16 sign-extended to WORD_SIZE. No arithmetic is performed in this block.

Decomposition:
- Shared parameters.v: WORD_SIZE, ALU_* opcodes, instruction field offsets, S_IDLE/S_STALL encodings.
- One natural sub-module, regfile_sb: register file plus busy scoreboard, with two read ports, one write port and bypass.

Test Plan:
- Reset then ADD r1,r0,imm=5 (use_imm=1) -> next cycle alu_enable=1, alu_op=ALU_ADD, alu_in1=0, alu_in2=5, alu_rd=1.
- Immediate 16'hFFFF -> alu_in2=32'hFFFFFFFF.
- Dependency stall: issue r1=r0+5, then SUB r2,r1,r1 -> instr_ready low and no alu_enable until wb_en, wb_addr=1, wb_data=12. On that same cycle the SUB issues next cycle with in1=in2=12 (bypass).
- WAW stall: MUL r3 then ADD r3 with no writeback -> second held. wb to r3 -> second issues, busy[r3] remains set.
- Illegal opcode 4'hF -> illegal pulses one cycle, no alu_enable, instr_ready stays 1.
- Assert rst_n=0 while in S_STALL -> outputs 0, busy cleared; after release a new independent instruction issues with 1-cycle latency.
